// File: rtl/lora_chirp_sequencer_pkg.sv
// Shared definitions for the LoRa chirp sequencer: FSM states, SF limits, phase precision.
// The optional SYNC_DOWNCHIRP_EN macro (used by the top) enables the downchirp sync field.
`ifndef PRECISION
`define PRECISION 25
`endif

package lora_chirp_sequencer_pkg;

  localparam int PREC = `PRECISION;
  localparam logic [3:0] SF_MIN = 4'd7;
  localparam logic [3:0] SF_MAX = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREAMBLE  = 3'd1,
    ST_SYNC      = 3'd2,
    ST_DATA_WAIT = 3'd3,
    ST_DATA_RUN  = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // N-1 for N = 2^sf; sf is at most 12, so the result fits in 12 bits.
  function automatic logic [11:0] sf_mask(input logic [3:0] sf);
    logic [12:0] n;
    n = 13'd1 << sf;
    return 12'(n - 13'd1);
  endfunction

endpackage

// File: rtl/chirp_phase_acc.sv
// Chirp phase accumulator: sample counter k and the phase word, stepping by
// ((sym+k) mod N) << s for upchirps or ((N-k) mod N) << s for downchirps.
module chirp_phase_acc
  import lora_chirp_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            down,
  input  logic [3:0]      sf,
  input  logic [11:0]     sym,
  output logic [11:0]     k,
  output logic            wrap,
  output logic [PREC-1:0] angle,
  output logic            angle_valid
);

  logic [11:0]     mask;
  logic [11:0]     val;
  logic [4:0]      shamt;
  logic [PREC-1:0] inc;

  always_comb begin
    mask  = sf_mask(sf);
    val   = down ? ((12'd0 - k) & mask) : ((sym + k) & mask);
    shamt = 5'(PREC) - {1'b0, sf};
    inc   = {{(PREC-12){1'b0}}, val} << shamt;
    wrap  = step && (k == mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k           <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
    end else if (clear) begin
      k           <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
    end else begin
      angle_valid <= step;
      if (step) begin
        angle <= angle + inc;
        k     <= wrap ? 12'd0 : k + 12'd1;
      end
    end
  end

endmodule

// File: rtl/lora_chirp_sequencer.sv
// LoRa frame sequencer: preamble upchirps, optional downchirp sync (SYNC_DOWNCHIRP_EN),
// then one upchirp per handshaked data symbol, driving a phase word for the cos/sine lookup.
module lora_chirp_sequencer
  import lora_chirp_sequencer_pkg::*;
#(
  parameter int SYNC_SYMS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      sf,
  input  logic [7:0]      preamble_len,
  input  logic            sample_en,
  input  logic            sym_valid,
  input  logic [11:0]     sym_data,
  input  logic            sym_last,
  output logic            sym_ready,
  output logic [PREC-1:0] angle,
  output logic            angle_valid,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output state_t          fsm_state
);

`ifdef SYNC_DOWNCHIRP_EN
  localparam state_t AFTER_PRE = ST_SYNC;
`else
  localparam state_t AFTER_PRE = ST_DATA_WAIT;
`endif

  state_t      state, next_state;
  logic [3:0]  sf_q;
  logic [7:0]  pre_q;
  logic [7:0]  cnt;
  logic [11:0] sym_q;
  logic        last_q;

  logic        step, wrap, clear, load_cfg, latch_sym, cnt_clr, cnt_inc, cfg_err_set;
  logic        down;
  logic [11:0] acc_sym;
  logic [11:0] k;

  // Symbol handshake: a data symbol transfers on a cycle where sym_valid && sym_ready;
  // sym_ready is high only in DATA_WAIT and the block never retracts it there.
  assign sym_ready = (state == ST_DATA_WAIT);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;
  assign down      = (state == ST_SYNC);
  assign acc_sym   = (state == ST_DATA_RUN) ? sym_q : 12'd0;
  assign step      = sample_en && !abort &&
                     (state == ST_PREAMBLE || state == ST_SYNC || state == ST_DATA_RUN);

  always_comb begin
    next_state  = state;
    clear       = 1'b0;
    load_cfg    = 1'b0;
    latch_sym   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cfg_err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (sf >= SF_MIN && sf <= SF_MAX) begin
            next_state = (preamble_len != 8'd0) ? ST_PREAMBLE : AFTER_PRE;
            clear      = 1'b1;
            load_cfg   = 1'b1;
            cnt_clr    = 1'b1;
          end else begin
            cfg_err_set = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (wrap) begin
          if (cnt == pre_q - 8'd1) begin
            next_state = AFTER_PRE;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      // Only reachable when the sync field is compiled in.
      ST_SYNC: begin
        if (wrap) begin
          if (cnt == 8'(SYNC_SYMS - 1)) begin
            next_state = ST_DATA_WAIT;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DATA_WAIT: begin
        if (sym_valid) begin
          latch_sym  = 1'b1;
          next_state = ST_DATA_RUN;
        end
      end
      ST_DATA_RUN: begin
        if (wrap) next_state = last_q ? ST_DONE : ST_DATA_WAIT;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    // Abort wins over everything, including a simultaneous start or handshake.
    if (abort) begin
      next_state  = ST_IDLE;
      clear       = 1'b1;
      load_cfg    = 1'b0;
      latch_sym   = 1'b0;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
      cfg_err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sf_q    <= SF_MIN;
      pre_q   <= '0;
      cnt     <= '0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= next_state;
      cfg_err <= cfg_err_set;
      if (load_cfg) begin
        sf_q  <= sf;
        pre_q <= preamble_len;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
      if (latch_sym) begin
        sym_q  <= sym_data & sf_mask(sf_q);
        last_q <= sym_last;
      end
    end
  end

  chirp_phase_acc u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .step        (step),
    .down        (down),
    .sf          (sf_q),
    .sym         (acc_sym),
    .k           (k),
    .wrap        (wrap),
    .angle       (angle),
    .angle_valid (angle_valid)
  );

  // k is internal to the accumulator's wrap decision; kept visible here for probing.
  logic k_unused;
  assign k_unused = ^k;

endmodule

// File: doc/lora_chirp_sequencer.md
LORA_CHIRP_SEQUENCER -- requirements
Module: lora_chirp_sequencer

Interface
REQ-001 Parameter SYNC_SYMS, default 2: number of downchirp sync symbols (1..3).
REQ-002 clk  input  1  block clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a frame when in IDLE.
REQ-005 abort  input  1  level; terminates any frame.
REQ-006 sf  input  4  spreading factor, legal 7..12, sampled on accepted start; N = 2^sf.
REQ-007 preamble_len  input  8  upchirp preamble count, sampled on accepted start; 0 legal.
REQ-008 sample_en  input  1  sample strobe; one chirp sample per asserted cycle.
REQ-009 sym_valid, sym_data[11:0], sym_last  input  1/12/1  data symbol handshake; sym_last marks the final symbol.
REQ-010 sym_ready  output  1  block accepts a symbol.
REQ-011 angle  output  `PRECISION  phase word driving the cosIdeal/sine lookup.
REQ-012 angle_valid  output  1  one-cycle pulse per updated angle.
REQ-013 busy, done, cfg_err  output  1 each  frame active; one-cycle frame-complete pulse; one-cycle illegal-sf pulse.

Function
REQ-014 States: IDLE, PREAMBLE, SYNC, DATA_WAIT, DATA_RUN, DONE.
REQ-015 IDLE + start + sf in 7..12 -> PREAMBLE (or SYNC if preamble_len==0); angle cleared to 0, k cleared, sym counter cleared.
REQ-016 IDLE + start + sf outside 7..12 -> stay IDLE, cfg_err pulses next cycle.
REQ-017 start outside IDLE is ignored.
REQ-018 Sample counter k (0..N-1) advances only on sample_en in PREAMBLE, SYNC or DATA_RUN; wraps N-1 -> 0 ending a symbol.
REQ-019 Shift s = `PRECISION - sf; upchirp increment inc = ((sym + k) mod N) << s; downchirp inc = ((N - k) mod N) << s.
REQ-020 On each counted sample: angle <= angle + inc, modulo 2^`PRECISION; angle_valid asserted the following cycle (latency 1 from sample_en).
REQ-021 Angle is phase-continuous across symbols and states; cleared only by reset, abort or accepted start.
REQ-022 PREAMBLE: preamble_len upchirps with sym=0, then SYNC.
REQ-023 SYNC: SYNC_SYMS downchirps, then DATA_WAIT.
REQ-024 DATA_WAIT: sym_ready=1; sym_valid&&sym_ready latches sym_data mod N and sym_last, k=0, -> DATA_RUN; sample_en ignored, angle held.
REQ-025 DATA_RUN: sym_ready=0; one upchirp with latched sym; at wrap -> DONE if latched sym_last else DATA_WAIT.
REQ-026 DONE: done pulses one cycle, then IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 abort in any state -> IDLE next cycle; angle=0; no done; abort overrides simultaneous start and handshake.

Reset
REQ-029 rst asserted -> state IDLE, k=0, angle=0, sym_ready=0, angle_valid=0, busy=0, done=0, cfg_err=0, immediately, regardless of clk.
REQ-030 Reset mid-frame discards the frame; first post-reset frame requires a new start.

Configuration
REQ-031 SYNC_DOWNCHIRP_EN defined: SYNC state present, as REQ-023.
REQ-032 SYNC_DOWNCHIRP_EN undefined: SYNC and SYNC_SYMS unused; PREAMBLE -> DATA_WAIT directly; preamble_len==0 -> DATA_WAIT.

Structure
REQ-033 State encodings, SF_MIN=7, SF_MAX=12 live in LoRaTXDefines.v; `PRECISION taken from there.
REQ-034 Single sub-module chirp_phase_acc: holds k and angle, computes inc from sym, direction and sf.

Verification
REQ-035 sf=7, preamble_len=1, SYNC on, sample_en every cycle, sym 5 last: angle_valid count = 128*(1+2+1); done once; angle after symbol 1 sample 1 = 0, sample 2 = 1<<18.
REQ-036 Data symbol sym=5, sf=7: first data-sample increment = 5<<18; increment at k=123 = 0.
REQ-037 start with sf=6 -> cfg_err pulse, busy stays 0; sf=13 likewise.
REQ-038 sym_valid held low 20 cycles in DATA_WAIT -> no angle_valid, angle unchanged; resumes on handshake.
REQ-039 abort during SYNC sample 40 -> IDLE next cycle, angle=0, no done; new start runs full frame.
REQ-040 SYNC_DOWNCHIRP_EN undefined, preamble_len=0, sf=12 -> sym_ready asserted one cycle after start; 4096 samples per symbol.
